// File: rtl/msm_arr_engine_if.sv
// Handshake and memory-port bundle for msm_arr_engine.
// slave: the engine side; master: the controller / memory side.
interface msm_arr_engine_if #(
  parameter int AWIDTH = 7
);
  logic              ap_start;
  logic              ap_done;
  logic              ap_idle;
  logic              ap_ready;

  logic [AWIDTH-1:0] P_arr_x_address0;
  logic [AWIDTH-1:0] P_arr_y_address0;
  logic [AWIDTH-1:0] P_arr_z_address0;
  logic [AWIDTH-1:0] K_arr_address0;
  logic              P_arr_x_ce0;
  logic              P_arr_y_ce0;
  logic              P_arr_z_ce0;
  logic              K_arr_ce0;
  logic [12:0]       P_arr_x_q0;
  logic [12:0]       P_arr_y_q0;
  logic [12:0]       P_arr_z_q0;
  logic [12:0]       K_arr_q0;

  logic [4:0]        B_i_address0;
  logic [4:0]        B_i_address1;
  logic              B_i_ce0;
  logic              B_i_ce1;
  logic              B_i_we0;
  logic              B_i_we1;
  logic [31:0]       B_i_d0;
  logic [31:0]       B_i_d1;

  modport slave (
    input  ap_start,
    output ap_done, ap_idle, ap_ready,
    output P_arr_x_address0, P_arr_y_address0, P_arr_z_address0, K_arr_address0,
    output P_arr_x_ce0, P_arr_y_ce0, P_arr_z_ce0, K_arr_ce0,
    input  P_arr_x_q0, P_arr_y_q0, P_arr_z_q0, K_arr_q0,
    output B_i_address0, B_i_address1, B_i_ce0, B_i_ce1,
    output B_i_we0, B_i_we1, B_i_d0, B_i_d1
  );

  modport master (
    output ap_start,
    input  ap_done, ap_idle, ap_ready,
    input  P_arr_x_address0, P_arr_y_address0, P_arr_z_address0, K_arr_address0,
    input  P_arr_x_ce0, P_arr_y_ce0, P_arr_z_ce0, K_arr_ce0,
    output P_arr_x_q0, P_arr_y_q0, P_arr_z_q0, K_arr_q0,
    input  B_i_address0, B_i_address1, B_i_ce0, B_i_ce1,
    input  B_i_we0, B_i_we1, B_i_d0, B_i_d1
  );
endinterface

// File: rtl/msm_arr_engine.sv
// MSM bucket-accumulation engine: streams N points and scalars, sorts each
// point into one of 32 buckets by a 5-bit scalar window, accumulates x/y
// modulo 8191 plus a saturating count, then dumps buckets two per cycle.
// Optional build macro: MSM_ARR_INF_SKIP_EN (points with z == 0 are skipped).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for ap_start; buckets cleared on acceptance
// READ    | k = 0..N: issue read k (k<N), accumulate point k-1 (k>=1)
// WRITE   | w = 0..15: write buckets 2w / 2w+1 on ports 0 / 1
// DONE    | one-cycle ap_done / ap_ready pulse
module msm_arr_engine #(
  parameter int AWIDTH    = 7,
  parameter int N         = 128,
  parameter int WIN_SHIFT = 0
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  msm_arr_engine_if.slave    bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [12:0]     P_MOD  = 13'd8191;
  localparam logic [AWIDTH:0] K_LAST = (AWIDTH+1)'(N);

  logic [1:0]        state_q;
  logic [AWIDTH:0]   k_q;
  logic [3:0]        w_q;
  logic [31:0]       bucket_q [32];

  logic              rd_en;
  logic              acc_phase;
  logic              acc_en;
  logic              wr_en;
  logic              pt_valid;
  logic [12:0]       x_red;
  logic [12:0]       y_red;
  logic [17:0]       k_ext;
  logic [4:0]        digit;
  logic [31:0]       cur_word;
  logic [5:0]        cnt_next;
  logic [31:0]       new_word;

  function automatic logic [12:0] mod_add(input logic [12:0] a, input logic [12:0] b);
    logic [13:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P_MOD}) s = s - {1'b0, P_MOD};
    return s[12:0];
  endfunction

  assign rd_en     = (state_q == ST_READ) && (k_q != K_LAST);
  assign acc_phase = (state_q == ST_READ) && (k_q != '0);
  assign wr_en     = (state_q == ST_WRITE);

  // 8191 is congruent to 0, so fold it before accumulation.
  assign x_red = (bus.P_arr_x_q0 == P_MOD) ? 13'd0 : bus.P_arr_x_q0;
  assign y_red = (bus.P_arr_y_q0 == P_MOD) ? 13'd0 : bus.P_arr_y_q0;

`ifdef MSM_ARR_INF_SKIP_EN
  logic [12:0] z_red;
  assign z_red    = (bus.P_arr_z_q0 == P_MOD) ? 13'd0 : bus.P_arr_z_q0;
  assign pt_valid = (z_red != 13'd0);
`else
  logic unused_z;
  assign unused_z = ^bus.P_arr_z_q0;
  assign pt_valid = 1'b1;
`endif

  // Zero-extended scalar so windows reaching past bit 12 read zeros.
  assign k_ext = {5'd0, bus.K_arr_q0};
  assign digit = 5'(k_ext >> WIN_SHIFT);

  assign acc_en   = acc_phase && pt_valid;
  assign cur_word = bucket_q[digit];
  assign cnt_next = (cur_word[5:0] == 6'd63) ? 6'd63 : cur_word[5:0] + 6'd1;
  assign new_word = {mod_add(cur_word[31:19], y_red),
                     mod_add(cur_word[18:6], x_red),
                     cnt_next};

  // Outputs decode from registered state, so reset forces them low at once.
  assign bus.ap_idle  = (state_q == ST_IDLE);
  assign bus.ap_done  = (state_q == ST_DONE);
  assign bus.ap_ready = (state_q == ST_DONE);

  assign bus.P_arr_x_address0 = rd_en ? k_q[AWIDTH-1:0] : '0;
  assign bus.P_arr_y_address0 = rd_en ? k_q[AWIDTH-1:0] : '0;
  assign bus.P_arr_z_address0 = rd_en ? k_q[AWIDTH-1:0] : '0;
  assign bus.K_arr_address0   = rd_en ? k_q[AWIDTH-1:0] : '0;
  assign bus.P_arr_x_ce0      = rd_en;
  assign bus.P_arr_y_ce0      = rd_en;
  assign bus.P_arr_z_ce0      = rd_en;
  assign bus.K_arr_ce0        = rd_en;

  assign bus.B_i_address0 = wr_en ? {w_q, 1'b0} : '0;
  assign bus.B_i_address1 = wr_en ? {w_q, 1'b1} : '0;
  assign bus.B_i_ce0      = wr_en;
  assign bus.B_i_ce1      = wr_en;
  assign bus.B_i_we0      = wr_en;
  assign bus.B_i_we1      = wr_en;
  assign bus.B_i_d0       = wr_en ? bucket_q[{w_q, 1'b0}] : '0;
  assign bus.B_i_d1       = wr_en ? bucket_q[{w_q, 1'b1}] : '0;

  // Sequencer: read index k, write index w, and phase transitions.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      w_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.ap_start) begin
            state_q <= ST_READ;
            k_q     <= '0;
          end
        end
        ST_READ: begin
          if (k_q == K_LAST) begin
            state_q <= ST_WRITE;
            w_q     <= '0;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        ST_WRITE: begin
          if (w_q == 4'd15) state_q <= ST_DONE;
          else              w_q     <= w_q + 4'd1;
        end
        default: begin
          state_q <= ST_IDLE;
          k_q     <= '0;
          w_q     <= '0;
        end
      endcase
    end
  end

  // Bucket file: cleared on run acceptance, one single-cycle update per point.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int i = 0; i < 32; i++) bucket_q[i] <= '0;
    end else if ((state_q == ST_IDLE) && bus.ap_start) begin
      for (int i = 0; i < 32; i++) bucket_q[i] <= '0;
    end else if (acc_en) begin
      bucket_q[digit] <= new_word;
    end
  end

endmodule

// File: tb/tb_msm_arr_engine.sv
// Self-checking bench for msm_arr_engine with a bucket reference model.
module tb_msm_arr_engine;

  localparam int AWIDTH    = 7;
  localparam int N         = 128;
  localparam int WIN_SHIFT = 0;
  localparam int P         = 8191;

  logic ap_clk;
  logic ap_rst;

  msm_arr_engine_if #(.AWIDTH(AWIDTH)) bus ();

  msm_arr_engine #(.AWIDTH(AWIDTH), .N(N), .WIN_SHIFT(WIN_SHIFT)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic [12:0] mem_x [N];
  logic [12:0] mem_y [N];
  logic [12:0] mem_z [N];
  logic [12:0] mem_k [N];

  logic [31:0] got_b   [32];
  logic [31:0] exp_b   [32];
  logic [31:0] first_b [32];

  int checks   = 0;
  int errors   = 0;
  int wr_cnt   = 0;
  int sync_err = 0;

  // Single-port memories with one cycle of read latency.
  always @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      bus.P_arr_x_q0 <= '0;
      bus.P_arr_y_q0 <= '0;
      bus.P_arr_z_q0 <= '0;
      bus.K_arr_q0   <= '0;
    end else begin
      if (bus.P_arr_x_ce0) bus.P_arr_x_q0 <= mem_x[bus.P_arr_x_address0];
      if (bus.P_arr_y_ce0) bus.P_arr_y_q0 <= mem_y[bus.P_arr_y_address0];
      if (bus.P_arr_z_ce0) bus.P_arr_z_q0 <= mem_z[bus.P_arr_z_address0];
      if (bus.K_arr_ce0)   bus.K_arr_q0   <= mem_k[bus.K_arr_address0];
    end
  end

  // Result memory capture plus port-consistency monitor, sampled mid-cycle.
  always @(negedge ap_clk) begin
    if (bus.B_i_ce0 && bus.B_i_we0) begin
      got_b[bus.B_i_address0] = bus.B_i_d0;
      wr_cnt++;
    end
    if (bus.B_i_ce1 && bus.B_i_we1) begin
      got_b[bus.B_i_address1] = bus.B_i_d1;
      wr_cnt++;
    end
    if (bus.B_i_ce0 !== bus.B_i_we0 || bus.B_i_ce1 !== bus.B_i_we1 ||
        bus.B_i_ce0 !== bus.B_i_ce1)
      sync_err++;
    if (bus.P_arr_x_ce0 !== bus.K_arr_ce0 || bus.P_arr_y_ce0 !== bus.K_arr_ce0 ||
        bus.P_arr_z_ce0 !== bus.K_arr_ce0 ||
        bus.P_arr_x_address0 !== bus.K_arr_address0 ||
        bus.P_arr_y_address0 !== bus.K_arr_address0 ||
        bus.P_arr_z_address0 !== bus.K_arr_address0)
      sync_err++;
    if (bus.ap_ready !== bus.ap_done) sync_err++;
  end

  // Reference: plain modular sums over the point list, bucket by bucket.
  function automatic void compute_model();
    int unsigned ex [32];
    int unsigned ey [32];
    int unsigned ec [32];
    int unsigned xr, yr, zr, d;
    for (int b = 0; b < 32; b++) begin
      ex[b] = 0; ey[b] = 0; ec[b] = 0;
    end
    for (int i = 0; i < N; i++) begin
      xr = (int'(mem_x[i]) == P) ? 0 : mem_x[i];
      yr = (int'(mem_y[i]) == P) ? 0 : mem_y[i];
      zr = (int'(mem_z[i]) == P) ? 0 : mem_z[i];
      d  = (int'(mem_k[i]) >> WIN_SHIFT) % 32;
`ifdef MSM_ARR_INF_SKIP_EN
      if (zr == 0) continue;
`else
      if (zr > 32'hFFFF) continue;
`endif
      ex[d] = (ex[d] + xr) % P;
      ey[d] = (ey[d] + yr) % P;
      if (ec[d] < 63) ec[d] = ec[d] + 1;
    end
    for (int b = 0; b < 32; b++) exp_b[b] = (ey[b] << 19) | (ex[b] << 6) | ec[b];
  endfunction

  task automatic fill_default();
    for (int i = 0; i < N; i++) begin
      mem_x[i] = '0; mem_y[i] = '0; mem_z[i] = 13'd1; mem_k[i] = '0;
    end
  endtask

  task automatic fill_random(input bit narrow);
    int r;
    for (int i = 0; i < N; i++) begin
      mem_x[i] = 13'($urandom_range(0, P));
      mem_y[i] = 13'($urandom_range(0, P));
      r = $urandom_range(0, 3);
      mem_z[i] = (r == 0) ? 13'd0 : (r == 1) ? 13'd8191 : 13'($urandom_range(1, P - 1));
      if (narrow) mem_k[i] = 13'(($urandom_range(0, 255) << 5) | $urandom_range(0, 2));
      else        mem_k[i] = 13'($urandom_range(0, P));
    end
  endtask

  // Pulses start, waits (bounded) for ap_done, then steps into the next cycle.
  task automatic run_dut(output int done_cyc, output int nwr, output logic idle_after);
    int cyc;
    int w0;
    for (int i = 0; i < 32; i++) got_b[i] = 32'hDEAD_BEEF;
    w0 = wr_cnt;
    @(negedge ap_clk) bus.ap_start = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk) bus.ap_start = 1'b0;
    cyc = 0;
    while (bus.ap_done !== 1'b1 && cyc < 400) begin
      @(negedge ap_clk);
      cyc++;
    end
    done_cyc = (cyc < 400) ? cyc : -1;
    @(negedge ap_clk);
    idle_after = bus.ap_idle;
    nwr = wr_cnt - w0;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    bus.ap_start = 1'b0;
    repeat (2) @(negedge ap_clk);
    checks++;
    if (bus.ap_idle !== 1'b1 || bus.ap_done !== 1'b0 || bus.ap_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_status idle=%b done=%b ready=%b want 1 0 0",
               bus.ap_idle, bus.ap_done, bus.ap_ready);
    end
    checks++;
    if ({bus.P_arr_x_ce0, bus.P_arr_y_ce0, bus.P_arr_z_ce0, bus.K_arr_ce0,
         bus.B_i_ce0, bus.B_i_ce1, bus.B_i_we0, bus.B_i_we1} !== 8'd0) begin
      errors++;
      $display("FAIL reset_enables got nonzero want 0");
    end
    checks++;
    if (bus.P_arr_x_address0 !== '0 || bus.K_arr_address0 !== '0 ||
        bus.B_i_address0 !== 5'd0 || bus.B_i_address1 !== 5'd0 ||
        bus.B_i_d0 !== 32'd0 || bus.B_i_d1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_addr_data got nonzero want 0");
    end
    @(negedge ap_clk) ap_rst = 1'b0;
    repeat (3) @(negedge ap_clk);
    checks++;
    if (bus.ap_idle !== 1'b1 || bus.P_arr_x_ce0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle idle=%b ce=%b want 1 0", bus.ap_idle, bus.P_arr_x_ce0);
    end
  endtask

  task automatic test_single_point();
    int dc, nw;
    logic ia;
    logic [31:0] want0;
    fill_default();
    for (int i = 0; i < N; i++) mem_z[i] = 13'd0;
    mem_k[5] = 13'd3; mem_x[5] = 13'd10; mem_y[5] = 13'd20; mem_z[5] = 13'd1;
    compute_model();
    run_dut(dc, nw, ia);
    checks++;
    if (dc != 145) begin errors++; $display("FAIL single_done_cycle got %0d want 145", dc); end
    checks++;
    if (nw != 32) begin errors++; $display("FAIL single_writes got %0d want 32", nw); end
    checks++;
    if (ia !== 1'b1) begin errors++; $display("FAIL single_idle_after got %b want 1", ia); end
    checks++;
    if (got_b[3] !== {13'd20, 13'd10, 6'd1}) begin
      errors++; $display("FAIL single_b3 got %h want %h", got_b[3], {13'd20, 13'd10, 6'd1});
    end
`ifdef MSM_ARR_INF_SKIP_EN
    want0 = 32'd0;
`else
    want0 = {13'd0, 13'd0, 6'd63};
`endif
    checks++;
    if (got_b[0] !== want0) begin
      errors++; $display("FAIL single_b0 got %h want %h", got_b[0], want0);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (got_b[i] !== exp_b[i]) begin
        errors++; $display("FAIL single_bucket %0d got %h want %h", i, got_b[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int dc, nw;
    logic ia;
    fill_default();
    for (int i = 10; i < 14; i++) begin
      mem_k[i] = 13'd7; mem_x[i] = 13'd4000; mem_y[i] = 13'd4000;
    end
    compute_model();
    run_dut(dc, nw, ia);
    checks++;
    if (got_b[7] !== {13'd7809, 13'd7809, 6'd4}) begin
      errors++; $display("FAIL wrap_b7 got %h want %h", got_b[7], {13'd7809, 13'd7809, 6'd4});
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (got_b[i] !== exp_b[i]) begin
        errors++; $display("FAIL wrap_bucket %0d got %h want %h", i, got_b[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int dc, nw;
    logic ia;
    fill_default();
    for (int i = 0; i < 100; i++) begin
      mem_k[i] = 13'd1; mem_x[i] = 13'd1; mem_y[i] = 13'd1;
    end
    compute_model();
    run_dut(dc, nw, ia);
    checks++;
    if (got_b[1] !== {13'd100, 13'd100, 6'd63}) begin
      errors++; $display("FAIL sat_b1 got %h want %h", got_b[1], {13'd100, 13'd100, 6'd63});
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (got_b[i] !== exp_b[i]) begin
        errors++; $display("FAIL sat_bucket %0d got %h want %h", i, got_b[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_infinity();
    int dc, nw;
    logic ia;
    logic [31:0] want2;
    fill_default();
    mem_k[40] = 13'd2; mem_x[40] = 13'd5; mem_y[40] = 13'd6; mem_z[40] = 13'd0;
    compute_model();
    run_dut(dc, nw, ia);
`ifdef MSM_ARR_INF_SKIP_EN
    want2 = 32'd0;
`else
    want2 = {13'd6, 13'd5, 6'd1};
`endif
    checks++;
    if (got_b[2] !== want2) begin
      errors++; $display("FAIL inf_b2 got %h want %h", got_b[2], want2);
    end
    checks++;
    if (dc != N + 17) begin errors++; $display("FAIL inf_done_cycle got %0d want %0d", dc, N + 17); end
  endtask

  task automatic test_random();
    int dc, nw;
    logic ia;
    for (int r = 0; r < 4; r++) begin
      fill_random(r[0]);
      compute_model();
      run_dut(dc, nw, ia);
      checks++;
      if (dc != N + 17 || nw != 32 || ia !== 1'b1) begin
        errors++;
        $display("FAIL rand_timing run %0d done=%0d writes=%0d idle=%b want %0d 32 1",
                 r, dc, nw, ia, N + 17);
      end
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (got_b[i] !== exp_b[i]) begin
          errors++; $display("FAIL rand_bucket run %0d b%0d got %h want %h", r, i, got_b[i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int dc, nw, w0;
    logic ia;
    fill_random(1'b0);
    compute_model();
    w0 = wr_cnt;
    @(negedge ap_clk) bus.ap_start = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk) bus.ap_start = 1'b0;
    repeat (60) @(negedge ap_clk);
    checks++;
    if (bus.P_arr_x_ce0 !== 1'b1) begin
      errors++; $display("FAIL midrst_running ce got %b want 1", bus.P_arr_x_ce0);
    end
    #2 ap_rst = 1'b1;
    #1;
    checks++;
    if (bus.ap_idle !== 1'b1 || bus.ap_done !== 1'b0 || bus.P_arr_x_ce0 !== 1'b0 ||
        bus.K_arr_address0 !== '0 || bus.B_i_we0 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_immediate idle=%b done=%b ce=%b addr=%0d we=%b want 1 0 0 0 0",
               bus.ap_idle, bus.ap_done, bus.P_arr_x_ce0, bus.K_arr_address0, bus.B_i_we0);
    end
    repeat (3) @(negedge ap_clk);
    ap_rst = 1'b0;
    repeat (200) @(negedge ap_clk);
    checks++;
    if (wr_cnt != w0) begin
      errors++; $display("FAIL midrst_no_writes got %0d writes want 0", wr_cnt - w0);
    end
    checks++;
    if (bus.ap_idle !== 1'b1) begin
      errors++; $display("FAIL midrst_stays_idle got %b want 1", bus.ap_idle);
    end
    run_dut(dc, nw, ia);
    checks++;
    if (dc != N + 17) begin errors++; $display("FAIL midrst_rerun_done got %0d want %0d", dc, N + 17); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (got_b[i] !== exp_b[i]) begin
        errors++; $display("FAIL midrst_bucket %0d got %h want %h", i, got_b[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    fill_random(1'b1);
    compute_model();
    for (int i = 0; i < 32; i++) got_b[i] = 32'hDEAD_BEEF;
    @(negedge ap_clk) bus.ap_start = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    cyc = 0;
    while (bus.ap_done !== 1'b1 && cyc < 400) begin
      @(negedge ap_clk);
      cyc++;
    end
    checks++;
    if (cyc != N + 17) begin errors++; $display("FAIL b2b_first_done got %0d want %0d", cyc, N + 17); end
    @(negedge ap_clk);
    checks++;
    if (bus.ap_idle !== 1'b1) begin errors++; $display("FAIL b2b_idle_entry got %b want 1", bus.ap_idle); end
    for (int i = 0; i < 32; i++) begin
      first_b[i] = got_b[i];
      got_b[i]   = 32'hDEAD_BEEF;
    end
    @(negedge ap_clk);
    checks++;
    if (bus.P_arr_x_ce0 !== 1'b1 || bus.P_arr_x_address0 !== '0 || bus.ap_idle !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart ce=%b addr=%0d idle=%b want 1 0 0",
               bus.P_arr_x_ce0, bus.P_arr_x_address0, bus.ap_idle);
    end
    bus.ap_start = 1'b0;
    cyc = 0;
    while (bus.ap_done !== 1'b1 && cyc < 400) begin
      @(negedge ap_clk);
      cyc++;
    end
    checks++;
    if (cyc != N + 17) begin errors++; $display("FAIL b2b_second_done got %0d want %0d", cyc, N + 17); end
    @(negedge ap_clk);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (first_b[i] !== exp_b[i] || got_b[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL b2b_bucket %0d run1 %h run2 %h want %h", i, first_b[i], got_b[i], exp_b[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_point();
    test_wrap();
    test_saturation();
    test_infinity();
    test_random();
    test_reset_mid_run();
    test_back_to_back();
    checks++;
    if (sync_err != 0) begin
      errors++; $display("FAIL port_consistency got %0d bad cycles want 0", sync_err);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
